pipe_stall_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage pipeline; sole driver of the `we` enables and the bubble selects of the PC, F/D, D/X and X/M pipeline latches.
- Decodes the instructions held in F/D and D/X.
- Sequences multi-cycle mul/div in X by holding the front of the pipe and issuing start pulses to the multdiv unit.
- Inserts load-use bubbles and squashes wrong-path instructions on a taken branch/jump.

---
 rtl/pipe_stall_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: drives the latch enables and bubble
// selects, sequences multi-cycle mul/div in X, and handles load-use and branch squash.
module pipe_stall_ctrl #(
    parameter int LATENCY = 32,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fd_instruction,
    input  logic [31:0] dx_instruction,
    input  logic        branch_taken,
    output logic        pc_we,
    output logic        fd_we,
    output logic        dx_we,
    output logic        xm_we,
    output logic        fd_bubble,
    output logic        dx_bubble,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {IDLE, MD_RUN, MD_DONE} state_t;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] md_count;

    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
    logic [4:0] dx_op, dx_rd, dx_aluop;
    logic       dx_is_mul, dx_is_div, dx_is_md;
    logic       fd_reads_rt, fd_reads_rd, load_use;

    assign fd_op    = fd_instruction[31:27];
    assign fd_rd    = fd_instruction[26:22];
    assign fd_rs    = fd_instruction[21:17];
    assign fd_rt    = fd_instruction[16:12];
    assign dx_op    = dx_instruction[31:27];
    assign dx_rd    = dx_instruction[26:22];
    assign dx_aluop = dx_instruction[6:2];

    // Fields this block never decodes.
    logic unused_bits;
    assign unused_bits = ^{fd_instruction[11:0], dx_instruction[21:7], dx_instruction[1:0]};

    assign dx_is_mul = (dx_op == OP_RTYPE) && (dx_aluop == ALU_MUL);
    assign dx_is_div = (dx_op == OP_RTYPE) && (dx_aluop == ALU_DIV);
    assign dx_is_md  = dx_is_mul || dx_is_div;

    // Stores and register-compare branches/jr carry a source operand in the rd field.
    assign fd_reads_rt = (fd_op == OP_RTYPE);
    assign fd_reads_rd = fd_op inside {OP_SW, OP_BNE, OP_BLT, OP_JR};

    assign load_use = (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                      ((fd_rs == dx_rd) ||
                       (fd_reads_rt && (fd_rt == dx_rd)) ||
                       (fd_reads_rd && (fd_rd == dx_rd)));

    assign md_busy = (state != IDLE);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        dx_we     = 1'b1;
        xm_we     = 1'b1;
        fd_bubble = 1'b0;
        dx_bubble = 1'b0;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        case (state)
            IDLE: begin
                // Mul/div start wins; a load-use hazard under a branch is squashed anyway.
                if (dx_is_md) begin
                    pc_we     = 1'b0;
                    fd_we     = 1'b0;
                    dx_we     = 1'b0;
                    xm_we     = 1'b0;
                    ctrl_mult = dx_is_mul;
                    ctrl_div  = dx_is_div;
                end else if (branch_taken) begin
                    fd_bubble = 1'b1;
                    dx_bubble = 1'b1;
                end else if (load_use) begin
                    pc_we     = 1'b0;
                    fd_we     = 1'b0;
                    dx_bubble = 1'b1;
                end
            end
            MD_RUN: begin
                pc_we = 1'b0;
                fd_we = 1'b0;
                dx_we = 1'b0;
                xm_we = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state        <= IDLE;
            md_count     <= '0;
            stall_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dx_is_md) begin
                        md_count <= LAT_CNT;
                        state    <= MD_RUN;
                    end
                end
                MD_RUN: begin
                    md_count <= md_count - CNT_ONE;
                    if (md_count == CNT_ONE) state <= MD_DONE;
                end
                MD_DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (!pc_we && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed vectors push hand-derived expectations,
// a negedge monitor pops and compares them against the DUT each cycle.
module tb_pipe_stall_ctrl;

    localparam int LATENCY = 32;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] MUL      = 32'h0000_0018;  // aluop 00110
    localparam logic [31:0] DIV      = 32'h0000_001C;  // aluop 00111
    localparam logic [31:0] LW_R3    = 32'h40C0_0000;  // lw rd=3
    localparam logic [31:0] LW_R0    = 32'h4004_0000;  // lw rd=0, rs=2
    localparam logic [31:0] ADD_RT3  = 32'h0142_3000;  // add rd=5 rs=1 rt=3
    localparam logic [31:0] SW_RD3   = 32'h38C0_0000;  // sw rd=3 (read)
    localparam logic [31:0] ADDI_RT3 = 32'h2800_3000;  // addi, rt field 3 not read
    localparam logic [31:0] ADDI_RS3 = 32'h2806_0000;  // addi rs=3

    // {pc_we, fd_we, dx_we, xm_we, fd_bubble, dx_bubble, ctrl_mult, ctrl_div, md_busy}
    localparam logic [8:0] O_DEF  = 9'b1111_00_00_0;
    localparam logic [8:0] O_MUL  = 9'b0000_00_10_0;
    localparam logic [8:0] O_DIV  = 9'b0000_00_01_0;
    localparam logic [8:0] O_RUN  = 9'b0000_00_00_1;
    localparam logic [8:0] O_DONE = 9'b1111_00_00_1;
    localparam logic [8:0] O_LU   = 9'b0011_01_00_0;
    localparam logic [8:0] O_BR   = 9'b1111_11_00_0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fd_instruction = '0;
    logic [31:0] dx_instruction = '0;
    logic        branch_taken = 1'b0;
    logic        pc_we, fd_we, dx_we, xm_we, fd_bubble, dx_bubble;
    logic        ctrl_mult, ctrl_div, md_busy;
    logic [31:0] stall_cycles;

    pipe_stall_ctrl #(.LATENCY(LATENCY), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .fd_instruction(fd_instruction), .dx_instruction(dx_instruction),
        .branch_taken(branch_taken),
        .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we), .xm_we(xm_we),
        .fd_bubble(fd_bubble), .dx_bubble(dx_bubble),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [8:0]  outs;
        logic [31:0] stall;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          mult_pulses = 0;
    int          div_pulses = 0;
    logic [31:0] exp_stall = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One cycle of stimulus plus its expected outputs; stall count tracks expected pc_we.
    task automatic step(input string name, input logic [31:0] fd, input logic [31:0] dx,
                        input logic br, input logic rst, input logic [8:0] outs);
        @(posedge clk);
        #1;
        reset          = rst;
        fd_instruction = fd;
        dx_instruction = dx;
        branch_taken   = br;
        sb.push_back('{name, outs, exp_stall});
        if (rst) exp_stall = '0;
        else if (!outs[8] && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.name, " outs"},
                  {23'd0, pc_we, fd_we, dx_we, xm_we, fd_bubble, dx_bubble, ctrl_mult, ctrl_div, md_busy},
                  {23'd0, mon_e.outs});
            check({mon_e.name, " stall_cycles"}, stall_cycles, mon_e.stall);
            if (ctrl_mult === 1'b1) mult_pulses++;
            if (ctrl_div === 1'b1) div_pulses++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        step("reset_release", NOP, NOP, 1'b0, 1'b0, O_DEF);

        // Full multiply sequence.
        step("mul_start", NOP, MUL, 1'b0, 1'b0, O_MUL);
        for (int i = 0; i < LATENCY; i++) step("mul_run", NOP, MUL, 1'b0, 1'b0, O_RUN);
        step("mul_done", NOP, MUL, 1'b0, 1'b0, O_DONE);
        step("mul_after", NOP, NOP, 1'b0, 1'b0, O_DEF);
        @(negedge clk); #1;
        check("mul_pulse_count", 32'(mult_pulses), 32'd1);
        check("stall_after_mul", stall_cycles, 32'd33);

        // Load-use hazards.
        step("lu_rt", ADD_RT3, LW_R3, 1'b0, 1'b0, O_LU);
        step("lu_rt_after", ADD_RT3, NOP, 1'b0, 1'b0, O_DEF);
        step("lu_sw_rd", SW_RD3, LW_R3, 1'b0, 1'b0, O_LU);
        step("lu_sw_after", SW_RD3, NOP, 1'b0, 1'b0, O_DEF);
        step("lu_rs", ADDI_RS3, LW_R3, 1'b0, 1'b0, O_LU);
        step("no_lu_rt_unread", ADDI_RT3, LW_R3, 1'b0, 1'b0, O_DEF);
        step("no_lu_r0", NOP, LW_R0, 1'b0, 1'b0, O_DEF);

        // Branch squash, and branch dropping a coincident load-use.
        step("branch", ADD_RT3, NOP, 1'b1, 1'b0, O_BR);
        step("branch_over_lu", ADD_RT3, LW_R3, 1'b1, 1'b0, O_BR);

        // Divide start beats a same-cycle branch; branch ignored while busy.
        step("div_start_br", NOP, DIV, 1'b1, 1'b0, O_DIV);
        for (int i = 0; i < LATENCY; i++)
            step("div_run", NOP, DIV, (i < 2) ? 1'b1 : 1'b0, 1'b0, O_RUN);
        step("div_done_br", NOP, DIV, 1'b1, 1'b0, O_DONE);
        step("div_after", NOP, NOP, 1'b0, 1'b0, O_DEF);
        @(negedge clk); #1;
        check("div_pulse_count", 32'(div_pulses), 32'd1);

        // Reset mid-sequence when the counter reads 10, then a clean restart.
        step("abort_start", NOP, MUL, 1'b0, 1'b0, O_MUL);
        for (int i = 0; i < LATENCY - 10; i++) step("abort_run", NOP, MUL, 1'b0, 1'b0, O_RUN);
        step("abort_reset", NOP, NOP, 1'b0, 1'b1, O_RUN);
        step("abort_idle", NOP, NOP, 1'b0, 1'b0, O_DEF);
        step("restart", NOP, MUL, 1'b0, 1'b0, O_MUL);
        for (int i = 0; i < LATENCY; i++) step("restart_run", NOP, MUL, 1'b0, 1'b0, O_RUN);
        step("restart_done", NOP, MUL, 1'b0, 1'b0, O_DONE);
        step("restart_after", NOP, NOP, 1'b0, 1'b0, O_DEF);
        @(negedge clk); #1;
        check("total_mul_pulses", 32'(mult_pulses), 32'd3);
        check("stall_after_restart", stall_cycles, 32'd33);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
